// File: rtl/dma_bus_pkg.sv
// rtl/dma_bus_pkg.sv - Shared bus widths, address map and status bit positions
package dma_bus_pkg;

  localparam int DATA_W = 32;

  localparam int unsigned RAM_TOP       = 1000;
  localparam int unsigned IO1_ADDR      = 1001;
  localparam int unsigned IO2_ADDR      = 1006;
  localparam int unsigned DMA_CTRL_ADDR = 5000;
  localparam int unsigned BUS_IDLE_ADDR = 7000;

  // Status register layout: {20'b0, underflow, overflow, count[9:0]}
  localparam int STAT_COUNT_W       = 10;
  localparam int STAT_OVERFLOW_BIT  = 10;
  localparam int STAT_UNDERFLOW_BIT = 11;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - Synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  // A push into a full FIFO or a pop from an empty one is ignored here too
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Storage write; contents are not reset because count gates their visibility
  always_ff @(posedge CLK) begin
    if (!RST && w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks net occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/dma_io_port.sv
// rtl/dma_io_port.sv - Bus-mapped receive FIFO endpoint raising DMA requests
module dma_io_port
  import dma_bus_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = IO1_ADDR,
  parameter int          DEPTH      = 4,
  parameter int          REQ_THRESH = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       address_Bus,
  inout  wire  [DATA_W-1:0] Data_Bus,
  input  logic              Read_DMA,
  input  logic              Write_DMA,
  input  logic              Read_CPU,
  input  logic              Write_CPU,
  output logic              DMA_Req,
  input  logic              dev_valid,
  input  logic [DATA_W-1:0] dev_data,
  output logic              dev_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              w_rd, w_wr, w_sel_d, w_sel_s;
  logic              w_push, w_pop, w_full, w_empty;
  logic              w_bus_oe;
  logic [CNT_W-1:0]  w_count, w_next_count;
  logic [DATA_W-1:0] w_head, w_status, w_bus_val;
  logic              r_underflow, r_overflow, r_dma_req, r_tx_valid;
  logic [DATA_W-1:0] r_tx_data;

  assign w_rd    = Read_DMA | Read_CPU;
  assign w_wr    = Write_DMA | Write_CPU;
  assign w_sel_d = (address_Bus == BASE_ADDR);
  assign w_sel_s = (address_Bus == BASE_ADDR + 1);

  assign dev_ready    = ~w_full;
  assign w_push       = dev_valid & dev_ready;
  assign w_pop        = w_rd & w_sel_d & ~w_empty & ~RST;
  assign w_next_count = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_rx_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (w_push),
    .pop   (w_pop),
    .din   (dev_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Assemble the status word from the sticky flags and current occupancy
  always_comb begin
    w_status = '0;
    w_status[STAT_COUNT_W-1:0]  = STAT_COUNT_W'(w_count);
    w_status[STAT_OVERFLOW_BIT]  = r_overflow;
    w_status[STAT_UNDERFLOW_BIT] = r_underflow;
  end

  // Bus is driven only for reads of our two addresses, and never during reset
  assign w_bus_oe  = ~RST & w_rd & (w_sel_d | w_sel_s);
  assign w_bus_val = w_sel_d ? (w_empty ? '0 : w_head) : w_status;
  assign Data_Bus  = w_bus_oe ? w_bus_val : 'z;

  // Sticky flags: a same-cycle set beats a status-register clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr && !w_rd && w_sel_s) begin
        r_underflow <= 1'b0;
        r_overflow  <= 1'b0;
      end
      if (w_rd && w_sel_d && w_empty) r_underflow <= 1'b1;
      if (dev_valid && w_full)        r_overflow  <= 1'b1;
    end
  end

  // Outbound word register; a concurrent read strobe suppresses the write
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_valid <= w_wr & ~w_rd & w_sel_d;
      if (w_wr && !w_rd && w_sel_d) r_tx_data <= Data_Bus;
    end
  end

  // Request reflects the occupancy that results from this cycle's push/pop
  always_ff @(posedge CLK) begin
    if (RST) r_dma_req <= 1'b0;
    else     r_dma_req <= (w_next_count >= CNT_W'(REQ_THRESH));
  end

  assign DMA_Req  = r_dma_req;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_dma_io_port.sv
// tb/tb_dma_io_port.sv - Randomized and directed self-checking bench for dma_io_port
module tb_dma_io_port;
  import dma_bus_pkg::*;

  localparam int DEPTH  = 4;
  localparam int THRESH = 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] addr;
  logic        rd_dma, rd_cpu, wr_dma, wr_cpu;
  logic        dev_valid;
  logic [31:0] dev_data;
  logic        drv_en;
  logic [31:0] drv_val;
  wire  [31:0] data_bus;
  logic        DMA_Req, dev_ready, tx_valid;
  logic [31:0] tx_data;

  assign data_bus = drv_en ? drv_val : 'z;

  dma_io_port #(.BASE_ADDR(IO1_ADDR), .DEPTH(DEPTH), .REQ_THRESH(THRESH)) dut (
    .CLK(CLK), .RST(RST), .address_Bus(addr), .Data_Bus(data_bus),
    .Read_DMA(rd_dma), .Write_DMA(wr_dma), .Read_CPU(rd_cpu), .Write_CPU(wr_cpu),
    .DMA_Req(DMA_Req), .dev_valid(dev_valid), .dev_data(dev_data),
    .dev_ready(dev_ready), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;

  // Reference model: queue of pending words plus flags and output registers
  logic [31:0] mq[$];
  bit          m_uf, m_of, m_req, m_txv;
  logic [31:0] m_txd;

  function automatic logic [31:0] exp_status();
    return {20'b0, m_uf, m_of, 10'(mq.size())};
  endfunction

  function automatic bit exp_oe();
    return !RST && (rd_dma || rd_cpu) && (addr == IO1_ADDR || addr == IO1_ADDR + 1);
  endfunction

  function automatic logic [31:0] exp_bus();
    if (addr == IO1_ADDR) return (mq.size() > 0) ? mq[0] : 32'h0;
    return exp_status();
  endfunction

  task automatic idle();
    rd_dma = 0; rd_cpu = 0; wr_dma = 0; wr_cpu = 0;
    dev_valid = 0; drv_en = 0; addr = BUS_IDLE_ADDR;
  endtask

  // Advance one clock, updating the model from the inputs presented at the edge
  task automatic tick();
    bit rd, wr, sd, ss, full, empty;
    rd = rd_dma | rd_cpu;
    wr = wr_dma | wr_cpu;
    sd = (addr == IO1_ADDR);
    ss = (addr == IO1_ADDR + 1);
    @(posedge CLK);
    if (RST) begin
      mq.delete(); m_uf = 0; m_of = 0; m_req = 0; m_txd = 0; m_txv = 0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      m_txv = 0;
      if (wr && !rd && sd) begin m_txd = drv_val; m_txv = 1; end
      if (wr && !rd && ss) begin m_uf = 0; m_of = 0; end
      if (rd && sd) begin
        if (empty) m_uf = 1;
        else void'(mq.pop_front());
      end
      if (dev_valid) begin
        if (full) m_of = 1;
        else mq.push_back(dev_data);
      end
      m_req = (mq.size() >= THRESH);
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1; idle(); dev_valid = 1; dev_data = 32'h1234; addr = IO1_ADDR; rd_dma = 1;
    #1;
    checks++; if (dut.w_bus_oe !== 1'b0) begin errs++; $display("FAIL rst_bus_z: got %0b want 0", dut.w_bus_oe); end
    tick(); tick();
    checks++; if (DMA_Req !== 1'b0) begin errs++; $display("FAIL rst_req: got %0b want 0", DMA_Req); end
    checks++; if (dev_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %0b want 1", dev_ready); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin errs++; $display("FAIL rst_tx: got %0b/%h want 0/0", tx_valid, tx_data); end
    RST = 0; idle(); addr = IO1_ADDR + 1; rd_cpu = 1; #1;
    checks++; if (data_bus !== 32'h0) begin errs++; $display("FAIL rst_status: got %h want 0", data_bus); end
    tick(); idle();
  endtask

  task automatic test_push_pop();
    idle(); dev_valid = 1; dev_data = 5; tick();
    checks++; if (DMA_Req !== 1'b1) begin errs++; $display("FAIL req_after_push: got %0b want 1", DMA_Req); end
    dev_data = 6; tick(); idle();
    addr = IO1_ADDR; rd_dma = 1; #1;
    checks++; if (data_bus !== 32'd5) begin errs++; $display("FAIL pop_first: got %h want 5", data_bus); end
    tick();
    checks++; if (data_bus !== 32'd6) begin errs++; $display("FAIL pop_second: got %h want 6", data_bus); end
    checks++; if (DMA_Req !== 1'b1) begin errs++; $display("FAIL req_mid: got %0b want 1", DMA_Req); end
    tick(); idle();
    checks++; if (DMA_Req !== 1'b0) begin errs++; $display("FAIL req_drop: got %0b want 0", DMA_Req); end
  endtask

  task automatic test_overflow_and_simul();
    idle();
    for (int i = 0; i < DEPTH; i++) begin dev_valid = 1; dev_data = $urandom; tick(); end
    checks++; if (dev_ready !== 1'b0) begin errs++; $display("FAIL full_ready: got %0b want 0", dev_ready); end
    dev_data = 32'hDEAD_BEEF; tick(); idle();
    addr = IO1_ADDR + 1; rd_cpu = 1; #1;
    checks++; if (data_bus !== 32'h0000_0404) begin errs++; $display("FAIL ovf_status: got %h want 00000404", data_bus); end
    tick(); idle();
    addr = IO1_ADDR + 1; wr_cpu = 1; drv_en = 1; drv_val = $urandom; tick(); idle();
    addr = IO1_ADDR + 1; rd_cpu = 1; #1;
    checks++; if (data_bus !== 32'h0000_0004) begin errs++; $display("FAIL ovf_clear: got %h want 00000004", data_bus); end
    idle();
    // Full: pop accepted while the offered word is stalled
    addr = IO1_ADDR; rd_dma = 1; dev_valid = 1; dev_data = 32'h0BAD_0BAD; #1;
    checks++; if (data_bus !== exp_bus()) begin errs++; $display("FAIL full_pop_data: got %h want %h", data_bus, exp_bus()); end
    tick(); idle();
    checks++; if (mq.size() != 3 || dev_ready !== 1'b1) begin errs++; $display("FAIL full_pop_cnt: got ready %0b want 1", dev_ready); end
    addr = IO1_ADDR; rd_dma = 1; tick();
    // Count 2: simultaneous push and pop keeps count and order
    dev_valid = 1; dev_data = 32'hC0FF_EE00; tick(); idle();
    addr = IO1_ADDR + 1; rd_cpu = 1; #1;
    checks++; if (data_bus[9:0] !== 10'd2) begin errs++; $display("FAIL simul_cnt: got %0d want 2", data_bus[9:0]); end
    idle(); addr = IO1_ADDR; rd_dma = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (data_bus !== exp_bus()) begin errs++; $display("FAIL simul_order%0d: got %h want %h", i, data_bus, exp_bus()); end
      tick();
    end
    idle(); addr = IO1_ADDR + 1; wr_cpu = 1; drv_en = 1; drv_val = 0; tick(); idle();
  endtask

  task automatic test_underflow();
    idle(); addr = IO1_ADDR; rd_dma = 1; #1;
    checks++; if (data_bus !== 32'h0) begin errs++; $display("FAIL empty_read: got %h want 0", data_bus); end
    tick(); idle(); addr = IO1_ADDR + 1; rd_cpu = 1; #1;
    checks++; if (data_bus !== 32'h0000_0800) begin errs++; $display("FAIL udf_status: got %h want 00000800", data_bus); end
    idle(); addr = IO1_ADDR + 1; wr_dma = 1; drv_en = 1; drv_val = 0; tick(); idle();
  endtask

  task automatic test_tx();
    idle(); addr = IO1_ADDR; wr_cpu = 1; drv_en = 1; drv_val = 32'hABCD; tick(); idle();
    checks++; if (tx_data !== 32'hABCD || tx_valid !== 1'b1) begin errs++; $display("FAIL tx_write: got %h/%0b want abcd/1", tx_data, tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL tx_pulse: got %0b want 0", tx_valid); end
  endtask

  task automatic test_rw_both();
    logic [31:0] w;
    w = $urandom;
    idle(); dev_valid = 1; dev_data = w; tick(); idle();
    addr = IO1_ADDR; rd_dma = 1; wr_cpu = 1; #1;
    checks++; if (data_bus !== w) begin errs++; $display("FAIL rw_read: got %h want %h", data_bus, w); end
    tick(); idle();
    checks++; if (tx_valid !== 1'b0 || tx_data !== 32'hABCD) begin errs++; $display("FAIL rw_nowrite: got %0b/%h want 0/abcd", tx_valid, tx_data); end
  endtask

  task automatic test_other_addr();
    logic [31:0] a[2];
    a[0] = IO2_ADDR; a[1] = BUS_IDLE_ADDR;
    for (int i = 0; i < 2; i++) begin
      idle(); addr = a[i]; rd_dma = 1; rd_cpu = 1; #1;
      checks++; if (dut.w_bus_oe !== 1'b0) begin errs++; $display("FAIL foreign_addr_%0d: got drive %0b want 0", a[i], dut.w_bus_oe); end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 3);
      addr = (r == 0) ? IO1_ADDR : (r == 1) ? IO1_ADDR + 1 : (r == 2) ? IO2_ADDR : BUS_IDLE_ADDR;
      rd_dma = ($urandom_range(0, 3) == 0); rd_cpu = ($urandom_range(0, 3) == 0);
      wr_dma = ($urandom_range(0, 4) == 0); wr_cpu = ($urandom_range(0, 4) == 0);
      dev_valid = $urandom_range(0, 1); dev_data = $urandom;
      RST = ($urandom_range(0, 39) == 0);
      drv_en = (wr_dma | wr_cpu) & ~(rd_dma | rd_cpu); drv_val = $urandom;
      #1;
      checks++; if (dut.w_bus_oe !== exp_oe()) begin errs++; $display("FAIL rnd_oe[%0d]: got %0b want %0b", n, dut.w_bus_oe, exp_oe()); end
      if (exp_oe()) begin
        checks++; if (data_bus !== exp_bus()) begin errs++; $display("FAIL rnd_bus[%0d]: got %h want %h", n, data_bus, exp_bus()); end
      end
      checks++; if (dev_ready !== (mq.size() < DEPTH)) begin errs++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, dev_ready, mq.size() < DEPTH); end
      tick();
      checks++; if (DMA_Req !== m_req) begin errs++; $display("FAIL rnd_req[%0d]: got %0b want %0b", n, DMA_Req, m_req); end
      checks++; if (tx_valid !== m_txv || tx_data !== m_txd) begin errs++; $display("FAIL rnd_tx[%0d]: got %0b/%h want %0b/%h", n, tx_valid, tx_data, m_txv, m_txd); end
    end
    RST = 0; idle();
  endtask

  initial begin
    idle(); RST = 1; dev_data = 0; drv_val = 0;
    test_reset();
    test_push_pop();
    test_overflow_and_simul();
    test_underflow();
    test_tx();
    test_rw_both();
    test_other_addr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
